// File: rtl/kbd_pkg.sv
// Shared scancode constants, state encoding and ROM address layout
// for the PS/2 keyboard decoder.
package kbd_pkg;

   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_BREAK  = 8'hF0;
   localparam logic [7:0] SC_PAUSE  = 8'hE1;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CAPS   = 8'h58;
   localparam logic [7:0] SC_CTRL   = 8'h14;

   localparam int ADDR_W     = 11;
   localparam int ADDR_LONG  = 10;
   localparam int ADDR_CAPS  = 9;
   localparam int ADDR_SHIFT = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOOKUP,
      ST_EMIT
   } state_t;

   // Receiver status / ack bytes that never denote a key
   function automatic logic is_nonkey(input logic [7:0] code);
      case (code)
         8'h00, 8'hAA, 8'hEE,
         8'hFA, 8'hFE, 8'hFF: return 1'b1;
         default:             return 1'b0;
      endcase
   endfunction

   function automatic logic [ADDR_W-1:0] make_addr(
      input logic       long,
      input logic       caps,
      input logic       shift,
      input logic [7:0] code
   );
      logic [ADDR_W-1:0] a;
      a = {3'b000, code};
      a[ADDR_LONG]  = long;
      a[ADDR_CAPS]  = caps;
      a[ADDR_SHIFT] = shift;
      return a;
   endfunction

endpackage

// File: rtl/kbd_modifiers.sv
// Shift / caps lock / ctrl tracking for the keyboard decoder.
// Ctrl tracking exists only when CTRL_KEY_EN is defined.
module kbd_modifiers
   import kbd_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] code,
   input  logic       code_valid,
   input  logic       long,
   input  logic       brk,
   output logic       shift,
   output logic       caps_lock,
   output logic       ctrl,
   output logic       consumed
);

   logic lshift;
   logic rshift;
   logic caps_held;
   logic ctrl_hit;

`ifdef CTRL_KEY_EN
   assign ctrl_hit = (code == SC_CTRL);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         ctrl <= 1'b0;
      else if (code_valid && ctrl_hit)
         ctrl <= !brk;
   end
`else
   assign ctrl_hit = 1'b0;
   assign ctrl     = 1'b0;
`endif

   // E0-prefixed shifts are fake shifts: swallowed but not tracked
   assign consumed = (code == SC_LSHIFT) || (code == SC_RSHIFT) ||
                     ((code == SC_CAPS) && !long) || ctrl_hit;

   assign shift = lshift | rshift;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lshift    <= 1'b0;
         rshift    <= 1'b0;
         caps_held <= 1'b0;
         caps_lock <= 1'b0;
      end else if (code_valid && !long) begin
         unique case (1'b1)
            code == SC_LSHIFT: lshift <= !brk;
            code == SC_RSHIFT: rshift <= !brk;
            code == SC_CAPS: begin
               if (brk) begin
                  caps_held <= 1'b0;
               end else if (!caps_held) begin
                  caps_lock <= !caps_lock;
                  caps_held <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/keyboard_decoder.sv
// PS/2 scancode to ASCII decoder with keymap ROM lookup and a one-entry
// valid/ready output. Optional ctrl-key folding under CTRL_KEY_EN.
module keyboard_decoder
   import kbd_pkg::*;
#(
   parameter int PAUSE_SKIP = 7
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  scancode,
   input  logic        scancode_valid,
   output logic [10:0] rom_addr,
   input  logic [7:0]  rom_dout,
   output logic [7:0]  ascii,
   output logic        ascii_valid,
   input  logic        ascii_ready,
   output logic        caps_lock,
   output logic        overflow
);

   localparam int SKIP_W = $clog2(PAUSE_SKIP + 1);

   state_t            state;
   state_t            state_nxt;
   logic              long;
   logic              brk;
   logic [SKIP_W-1:0] skip;
   logic              shift;
   logic              ctrl;
   logic              consumed;
   logic              idle_byte;
   logic              key_byte;
   logic              prefix;
   logic              lookup;
   logic [7:0]        char_out;
   logic              have_char;
   logic              load;
   logic              drop;

   assign idle_byte = (state == ST_IDLE) && scancode_valid;
   assign key_byte  = idle_byte && (skip == '0);
   assign prefix    = (scancode == SC_EXT) || (scancode == SC_BREAK) ||
                      (scancode == SC_PAUSE);
   assign lookup    = key_byte && !prefix && !is_nonkey(scancode) &&
                      !consumed && !brk;

   kbd_modifiers u_mod (
      .clk        (clk),
      .reset      (reset),
      .code       (scancode),
      .code_valid (key_byte),
      .long       (long),
      .brk        (brk),
      .shift      (shift),
      .caps_lock  (caps_lock),
      .ctrl       (ctrl),
      .consumed   (consumed)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:   if (lookup) state_nxt = ST_LOOKUP;
         ST_LOOKUP: state_nxt = ST_EMIT;
         ST_EMIT:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // A same-cycle accept frees the slot, so the new char is not dropped
   always_comb begin
      char_out = rom_dout;
      if (ctrl && (rom_dout[7:6] == 2'b01))
         char_out = {3'b000, rom_dout[4:0]};
      have_char = (state == ST_EMIT) && (rom_dout != 8'h00);
      load      = have_char && (!ascii_valid || ascii_ready);
      drop      = have_char && ascii_valid && !ascii_ready;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         long <= 1'b0;
         brk  <= 1'b0;
         skip <= '0;
      end else if (key_byte) begin
         unique case (1'b1)
            scancode == SC_EXT:   long <= 1'b1;
            scancode == SC_BREAK: brk  <= 1'b1;
            scancode == SC_PAUSE: begin
               skip <= SKIP_W'(PAUSE_SKIP);
               long <= 1'b0;
               brk  <= 1'b0;
            end
            default: begin
               long <= 1'b0;
               brk  <= 1'b0;
            end
         endcase
      end else if (idle_byte) begin
         skip <= skip - SKIP_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rom_addr    <= '0;
         ascii       <= '0;
         ascii_valid <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         if (lookup)
            rom_addr <= make_addr(long, caps_lock, shift, scancode);
         if (load) begin
            ascii       <= char_out;
            ascii_valid <= 1'b1;
         end else if (ascii_valid && ascii_ready) begin
            ascii_valid <= 1'b0;
         end
         if (drop)
            overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_keyboard_decoder.sv
// Directed bench for keyboard_decoder: behavioural scancode model with a
// per-cycle compare, plus literal checks of the documented sequences.
module tb_keyboard_decoder;

   localparam int PAUSE_SKIP = 7;

   logic        clk;
   logic        reset;
   logic [7:0]  scancode;
   logic        scancode_valid;
   logic [10:0] rom_addr;
   logic [7:0]  rom_dout;
   logic [7:0]  ascii;
   logic        ascii_valid;
   logic        ascii_ready;
   logic        caps_lock;
   logic        overflow;

   keyboard_decoder #(.PAUSE_SKIP(PAUSE_SKIP)) dut (
      .clk            (clk),
      .reset          (reset),
      .scancode       (scancode),
      .scancode_valid (scancode_valid),
      .rom_addr       (rom_addr),
      .rom_dout       (rom_dout),
      .ascii          (ascii),
      .ascii_valid    (ascii_valid),
      .ascii_ready    (ascii_ready),
      .caps_lock      (caps_lock),
      .overflow       (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] rom [0:2047];

   always @(posedge clk) rom_dout <= rom[rom_addr];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   task automatic check(input string name, input logic [15:0] act,
                        input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d",
                  name, act, exp, cyc);
      end
   endtask

   // Behavioural model of the keyboard state and the output register
   logic        m_long, m_brk, m_ls, m_rs, m_held, m_caps, m_ctrl;
   int          m_skip;
   logic [10:0] m_addr;
   logic [7:0]  m_ascii;
   logic        m_valid, m_ovf, m_pend;
   int          m_due;
   logic [7:0]  m_char;

   task automatic model_clear();
      m_long = 0; m_brk = 0; m_ls = 0; m_rs = 0; m_held = 0;
      m_caps = 0; m_ctrl = 0; m_skip = 0; m_addr = 0; m_ascii = 0;
      m_valid = 0; m_ovf = 0; m_pend = 0; m_due = 0; m_char = 0;
   endtask

   task automatic model_byte(input logic [7:0] b);
      logic lk, bk;
      if (m_skip > 0) begin
         m_skip--;
         return;
      end
      if (b == 8'hE0) begin
         m_long = 1;
         return;
      end
      if (b == 8'hF0) begin
         m_brk = 1;
         return;
      end
      lk = m_long;
      bk = m_brk;
      m_long = 0;
      m_brk  = 0;
      if (b == 8'hE1) begin
         m_skip = PAUSE_SKIP;
      end else if (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF}) begin
      end else if (b == 8'h12 || b == 8'h59) begin
         if (!lk && b == 8'h12) m_ls = !bk;
         if (!lk && b == 8'h59) m_rs = !bk;
      end else if (b == 8'h58 && !lk) begin
         if (bk) m_held = 0;
         else if (!m_held) begin
            m_caps = !m_caps;
            m_held = 1;
         end
`ifdef CTRL_KEY_EN
      end else if (b == 8'h14) begin
         m_ctrl = !bk;
`endif
      end else if (!bk) begin
         m_addr = {lk, m_caps, m_ls | m_rs, b};
         m_char = rom[m_addr];
         if (m_ctrl && m_char >= 8'h40 && m_char <= 8'h7F)
            m_char = m_char & 8'h1F;
         m_pend = 1;
         m_due  = cyc + 2;
      end
   endtask

   always @(posedge clk) begin
      cyc++;
      if (reset) begin
         model_clear();
      end else begin
         if (m_pend && cyc == m_due) begin
            m_pend = 0;
            if (m_char != 8'h00) begin
               if (!m_valid || ascii_ready) begin
                  m_ascii = m_char;
                  m_valid = 1;
               end else begin
                  m_ovf = 1;
               end
            end else if (m_valid && ascii_ready) begin
               m_valid = 0;
            end
         end else if (m_valid && ascii_ready) begin
            m_valid = 0;
         end
         if (scancode_valid && !m_pend)
            model_byte(scancode);
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         check("model rom_addr", 16'(rom_addr), 16'(m_addr));
         check("model ascii_valid", 16'(ascii_valid), 16'(m_valid));
         if (m_valid)
            check("model ascii", 16'(ascii), 16'(m_ascii));
         check("model caps_lock", 16'(caps_lock), 16'(m_caps));
         check("model overflow", 16'(overflow), 16'(m_ovf));
      end
   end

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      scancode       = b;
      scancode_valid = 1'b1;
      @(negedge clk);
      scancode_valid = 1'b0;
   endtask

   task automatic sendw(input logic [7:0] b);
      send(b);
      repeat (3) @(negedge clk);
   endtask

   // Returns just after the edge where a looked-up char is loaded
   task automatic send_emit(input logic [7:0] b);
      send(b);
      @(posedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 2048; i++) rom[i] = 8'h00;
      rom[11'h01C] = 8'h61;
      rom[11'h11C] = 8'h41;
      rom[11'h21C] = 8'h41;
      rom[11'h032] = 8'h62;
      rom[11'h021] = 8'h63;
      model_clear();
      reset          = 1'b1;
      scancode       = 8'h00;
      scancode_valid = 1'b0;
      ascii_ready    = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      check("reset rom_addr", 16'(rom_addr), 16'h000);
      check("reset ascii", 16'(ascii), 16'h00);
      check("reset ascii_valid", 16'(ascii_valid), 16'h0);
      check("reset caps_lock", 16'(caps_lock), 16'h0);
      check("reset overflow", 16'(overflow), 16'h0);

      // Plain make then break
      send_emit(8'h1C);
      check("1C rom_addr", 16'(rom_addr), 16'h01C);
      check("1C ascii_valid", 16'(ascii_valid), 16'h1);
      check("1C ascii", 16'(ascii), 16'h61);
      settle();
      sendw(8'hF0);
      sendw(8'h1C);
      check("1C break no emit", 16'(ascii_valid), 16'h0);

      // Shifted key then released shift
      sendw(8'h12);
      send_emit(8'h1C);
      check("shift rom_addr", 16'(rom_addr), 16'h11C);
      check("shift ascii", 16'(ascii), 16'h41);
      settle();
      sendw(8'hF0);
      sendw(8'h12);
      send_emit(8'h1C);
      check("unshift rom_addr", 16'(rom_addr), 16'h01C);
      check("unshift ascii", 16'(ascii), 16'h61);
      settle();

      // Caps lock with auto-repeat
      sendw(8'h58);
      sendw(8'h58);
      check("caps after repeat", 16'(caps_lock), 16'h1);
      sendw(8'hF0);
      sendw(8'h58);
      send_emit(8'h1C);
      check("caps rom_addr", 16'(rom_addr), 16'h21C);
      check("caps ascii", 16'(ascii), 16'h41);
      settle();
      sendw(8'h58);
      sendw(8'hF0);
      sendw(8'h58);
      check("caps off", 16'(caps_lock), 16'h0);

      // Extended key and Pause sequence
      sendw(8'hE0);
      sendw(8'h75);
      check("ext rom_addr", 16'(rom_addr), 16'h475);
      sendw(8'hE1);
      sendw(8'h14);
      sendw(8'h77);
      sendw(8'hE1);
      sendw(8'hF0);
      sendw(8'h14);
      sendw(8'hF0);
      sendw(8'h77);
      check("pause no lookup", 16'(rom_addr), 16'h475);
      send_emit(8'h1C);
      check("after pause rom_addr", 16'(rom_addr), 16'h01C);
      check("after pause ascii", 16'(ascii), 16'h61);
      settle();

      // Fake shift ignored, status byte discarded
      sendw(8'hE0);
      sendw(8'h12);
      sendw(8'hAA);
      send_emit(8'h1C);
      check("fake shift rom_addr", 16'(rom_addr), 16'h01C);
      settle();

`ifdef CTRL_KEY_EN
      sendw(8'h14);
      send_emit(8'h21);
      check("ctrl rom_addr", 16'(rom_addr), 16'h021);
      check("ctrl ascii", 16'(ascii), 16'h03);
      settle();
      sendw(8'hF0);
      sendw(8'h14);
`else
      sendw(8'h14);
      check("plain 14 rom_addr", 16'(rom_addr), 16'h014);
      check("plain 14 no emit", 16'(ascii_valid), 16'h0);
`endif

      // Output full: second char dropped
      @(negedge clk);
      ascii_ready = 1'b0;
      sendw(8'h1C);
      sendw(8'h32);
      check("full ascii", 16'(ascii), 16'h61);
      check("full ascii_valid", 16'(ascii_valid), 16'h1);
      check("full overflow", 16'(overflow), 16'h1);
      @(negedge clk);
      ascii_ready = 1'b1;
      @(negedge clk);
      ascii_ready = 1'b0;
      #1;
      check("accept clears valid", 16'(ascii_valid), 16'h0);
      check("overflow sticky", 16'(overflow), 16'h1);
      @(negedge clk);
      ascii_ready = 1'b1;

      // Reset during lookup loses the pending char
      send(8'h1C);
      #2;
      reset = 1'b1;
      @(negedge clk);
      #1;
      check("reset mid rom_addr", 16'(rom_addr), 16'h000);
      check("reset mid overflow", 16'(overflow), 16'h0);
      #1;
      reset = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      check("reset mid no emit", 16'(ascii_valid), 16'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
